imem_loader: RTL
================

# imem_loader

Byte-stream writer for the processor's 512-byte instruction memory. It accepts a handshaked stream of instruction bytes and writes them to consecutive addresses starting at 0. It holds the pipeline (PC/nPC, stage registers) in reset until the image has been fully written, and it flags overruns. It supplies the write port that fetch never drives, and it replaces file preloading so that images can be reloaded at runtime.

## Interface
Parameters:
- ADDR_WIDTH, default 9: instruction memory address width.
- DEPTH, default 512: number of byte locations; must equal 2**ADDR_WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  instruction byte, big-endian order within each 32-bit word, as instruction memory expects.
- byte_last  in  1  qualifies the current byte as the final byte of the image.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction memory write enable, registered.
- mem_addr  out  ADDR_WIDTH  write address, registered.
- mem_data  out  8  write data, registered.
- cpu_hold  out  1  pipeline reset request; ORed with reset at the top level.
- done  out  1  image loaded, pipeline released.
- error  out  1  overrun; stream exceeded DEPTH bytes.
- byte_count  out  ADDR_WIDTH+1  bytes written in the current or last load (0..DEPTH).
- checksum  out  8  modulo-256 sum of accepted bytes.

## Operation
- States: IDLE, LOAD, FINISH, DONE, ERROR.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - start=1 -> LOAD; wr_ptr, byte_count and checksum cleared to 0 on the same edge.
- LOAD:
  - byte_ready=1; start is ignored.
  - Each accepted byte:
    - mem_we=1, mem_addr=wr_ptr, mem_data=byte_data during the following cycle.
    - wr_ptr+1, byte_count+1, checksum+=byte_data (8-bit wrap).
  - Without an accepted byte, mem_we=0 in the following cycle.
  - Accepted byte with byte_last=1 -> FINISH.
  - Accepted byte at wr_ptr=DEPTH-1 with byte_last=0: the byte is still written, byte_count=DEPTH, then -> ERROR.
  - Accepted byte at wr_ptr=DEPTH-1 with byte_last=1 -> FINISH (exact fill is legal).
- FINISH:
  - One cycle; byte_ready=0; the last write is in flight.
  - -> DONE.
- DONE:
  - done=1, cpu_hold=0, byte_ready=0.
  - start=1 -> LOAD (reload), with the same clearing as from IDLE; cpu_hold returns to 1.
- ERROR:
  - error=1, cpu_hold=1, byte_ready=0.
  - start=1 -> LOAD with clearing.
- wr_ptr is ADDR_WIDTH bits wide. It never wraps into a write: the overrun path leaves LOAD before a wrapped address is used.
- Memory contents are never cleared by the loader. Locations beyond the loaded image keep their previous values.

## Timing
- Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, error=0, byte_count=0, checksum=0.
- byte_ready, done, error and cpu_hold are registered decodes of state. They change on the edge after the transition condition is sampled.
- start at edge N -> byte_ready=1 from cycle N+1. Throughput is 1 byte/cycle with byte_valid held high.
- Write latency is 1: a byte accepted at edge N is written into memory at edge N+1.
- Last byte accepted at edge N:
  - its mem_we is high in cycle N..N+1;
  - state=FINISH after N, DONE after N+1;
  - done=1 and cpu_hold=0 are first visible after edge N+2.
- The pipeline is therefore never released before the final write lands.
- byte_valid while byte_ready=0 is not accepted. The source must hold the byte, and nothing is consumed.
- reset in any cycle, including mid-LOAD with byte_valid=1: the next state is IDLE with all reset values. The byte presented on that edge is not written, and no mem_we pulse follows.
- reset and start on the same edge: reset wins.

## Test plan
- Reset, then start; stream 8 bytes 0x01..0x08 with byte_last on 0x08:
  - mem writes at addr 0..7 with matching data, one per cycle;
  - byte_count=8, checksum=0x24;
  - done=1 and cpu_hold=0 two cycles after the last acceptance.
- Throttled source, byte_valid toggling every other cycle for 4 bytes 0xAA:
  - exactly 4 mem_we pulses at addr 0..3;
  - checksum=0xA8.
- Overrun: 513 bytes, byte_last never asserted:
  - 512 writes, the last at addr 511;
  - error=1, byte_count=512, byte_ready=0, cpu_hold=1;
  - byte 513 not accepted.
- Exact fill: 512 bytes with byte_last on the 512th -> done=1, error=0, byte_count=512.
- Assert reset after 3 of 6 bytes -> IDLE, no further mem_we, cpu_hold=1, byte_count=0. A following start plus a 2-byte load ends with done=1 and byte_count=2.
- From DONE, start with a new 4-byte image -> cpu_hold rises the cycle after start, addresses restart at 0, done=1 again after completion.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Writes a handshaked byte stream into the 512-byte instruction memory, starting
// at address 0. The pipeline is held in reset until the whole image has landed.
// A stream longer than the memory is flagged as an overrun.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle load request (honoured in IDLE, DONE, ERROR)
//   byte_valid/data   incoming instruction byte (big-endian within each word)
//   byte_last         marks the final byte of the image
//   byte_ready        loader accepts a byte this cycle
//   mem_we/addr/data  registered write port into instruction memory
//   cpu_hold          pipeline reset request, ORed with reset at top level
//   done / error      image loaded / stream overran the memory
//   byte_count        bytes written in the current or last load
//   checksum          modulo-256 sum of accepted bytes
module imem_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic [7:0]            checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [7:0]            sum_q;
    logic                  ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  hold_q;
    logic                  done_q;
    logic                  error_q;
    logic                  accept;
    logic                  start_load;

    // Next-state selection. ready_q is only ever high while loading, so an
    // accepted byte implies we are in LOAD. The overrun check uses wr_ptr
    // before it increments, so the wrapped pointer value is never written.
    always_comb begin
        state_d    = state_q;
        accept     = byte_valid && ready_q;
        start_load = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_ERROR));
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_load) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (byte_last) begin
                        state_d = S_FINISH;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state and outputs are registered here. byte_ready tracks the state
    // being entered, so it drops on the same edge that leaves LOAD and no
    // extra byte slips in. The status flags decode the state being left,
    // which releases the pipeline one cycle after DONE is reached, i.e. only
    // once the final write has landed in memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_LOAD);
            hold_q  <= (state_q != S_DONE);
            done_q  <= (state_q == S_DONE);
            error_q <= (state_q == S_ERROR);
            we_q    <= accept;
            if (accept) begin
                addr_q <= wr_ptr_q;
                data_q <= byte_data;
            end
            if (start_load) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                sum_q    <= '0;
            end else if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 1'b1;
                sum_q    <= sum_q + byte_data;
            end
        end
    end

    assign byte_ready = ready_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;
    assign checksum   = sum_q;

endmodule
